// File: rtl/gpr_access_ctrl_if.sv
// Requester-side bundle for gpr_access_ctrl: the two core datapath ports and the debug port.
interface gpr_access_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) ();
    logic              iCoreReqA;
    logic              iCoreWrA;
    logic [ADDR_W-1:0] iCoreAddrA;
    logic [DATA_W-1:0] iCoreDataA;
    logic [DATA_W-1:0] oCoreDataA;
    logic              oCoreValidA;

    logic              iCoreReqB;
    logic              iCoreWrB;
    logic [ADDR_W-1:0] iCoreAddrB;
    logic [DATA_W-1:0] iCoreDataB;
    logic [DATA_W-1:0] oCoreDataB;
    logic              oCoreValidB;

    logic              iDbgReq;
    logic              iDbgWr;
    logic [ADDR_W-1:0] iDbgAddr;
    logic [DATA_W-1:0] iDbgData;
    logic              oDbgGnt;
    logic              oDbgAck;
    logic [DATA_W-1:0] oDbgData;

    modport master (
        output iCoreReqA, iCoreWrA, iCoreAddrA, iCoreDataA,
        input  oCoreDataA, oCoreValidA,
        output iCoreReqB, iCoreWrB, iCoreAddrB, iCoreDataB,
        input  oCoreDataB, oCoreValidB,
        output iDbgReq, iDbgWr, iDbgAddr, iDbgData,
        input  oDbgGnt, oDbgAck, oDbgData
    );

    modport slave (
        input  iCoreReqA, iCoreWrA, iCoreAddrA, iCoreDataA,
        output oCoreDataA, oCoreValidA,
        input  iCoreReqB, iCoreWrB, iCoreAddrB, iCoreDataB,
        output oCoreDataB, oCoreValidB,
        input  iDbgReq, iDbgWr, iDbgAddr, iDbgData,
        output oDbgGnt, oDbgAck, oDbgData
    );
endinterface

// File: rtl/gpr_access_ctrl.sv
// Access controller for the dual-port GPR file: post-reset clear, debug arbitration on
// port B, same-address write collision resolution and write-to-read forwarding.
module gpr_access_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              iClk,
    input  logic              iRst,
    gpr_access_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] oAddrA,
    output logic [DATA_W-1:0] oDInA,
    output logic              oWriteA,
    input  logic [DATA_W-1:0] iDOutA,
    output logic [ADDR_W-1:0] oAddrB,
    output logic [DATA_W-1:0] oDInB,
    output logic              oWriteB,
    input  logic [DATA_W-1:0] iDOutB,
    output logic              oReady,
    output logic              oCollide
);
    localparam int CLR_W = ADDR_W - 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(DEPTH / 2 - 1);
    localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t            rState;
    logic [CLR_W-1:0]  rClr;
    logic              rReady, rValidA, rValidB, rDbgAck, rDbgRd, rCollide, rFwdA, rFwdB;
    logic [DATA_W-1:0] rFwdDataA, rFwdDataB, rHoldA, rHoldB, rDbgHold, rDInA, rDInB;
    logic [ADDR_W-1:0] rAddrA, rAddrB;

    logic              run, coreRdA, coreRdB, dbgGnt, dbgRd, wrReqB, sameAddr, suppressB, fwdA, fwdB;
    logic              writeA, writeB;
    logic [ADDR_W-1:0] addrA, addrB;
    logic [DATA_W-1:0] dinA, dinB, rdDataA, rdDataB;

    // Port steering: clear sweep, core pass-through, debug on B when core B is idle.
    always_comb begin
        run     = (rState == RUN) && !iRst;
        coreRdA = run && bus.iCoreReqA && !bus.iCoreWrA;
        coreRdB = run && bus.iCoreReqB && !bus.iCoreWrB;
        dbgGnt  = run && bus.iDbgReq && !bus.iCoreReqB;
        dbgRd   = dbgGnt && !bus.iDbgWr;
        addrA   = rAddrA;
        dinA    = rDInA;
        writeA  = 1'b0;
        addrB   = rAddrB;
        dinB    = rDInB;
        wrReqB  = 1'b0;
        if (!iRst && (rState == CLEAR)) begin
            addrA  = {rClr, 1'b0};
            dinA   = {DATA_W{1'b0}};
            writeA = 1'b1;
            addrB  = {rClr, 1'b1};
            dinB   = {DATA_W{1'b0}};
            wrReqB = 1'b1;
        end else if (run) begin
            if (bus.iCoreReqA) begin
                addrA  = bus.iCoreAddrA;
                dinA   = bus.iCoreDataA;
                writeA = bus.iCoreWrA;
            end else begin
                writeA = 1'b0;
            end
            if (bus.iCoreReqB) begin
                addrB  = bus.iCoreAddrB;
                dinB   = bus.iCoreDataB;
                wrReqB = bus.iCoreWrB;
            end else if (dbgGnt) begin
                addrB  = bus.iDbgAddr;
                dinB   = bus.iDbgData;
                wrReqB = bus.iDbgWr;
            end else begin
                wrReqB = 1'b0;
            end
        end else begin
            writeA = 1'b0;
            wrReqB = 1'b0;
        end
        // Port A wins a same-address write; a read opposite an actual write takes its data.
        sameAddr  = (addrA == addrB);
        suppressB = writeA && wrReqB && sameAddr;
        writeB    = wrReqB && !suppressB;
        fwdA      = coreRdA && writeB && sameAddr;
        fwdB      = (coreRdB || dbgRd) && writeA && sameAddr;
        rdDataA   = rFwdA ? rFwdDataA : iDOutA;
        rdDataB   = rFwdB ? rFwdDataB : iDOutB;
    end

    // Clear/run sequencing plus all response-side registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rState    <= CLEAR;
            rClr      <= {CLR_W{1'b0}};
            rReady    <= 1'b0;
            rValidA   <= 1'b0;
            rValidB   <= 1'b0;
            rDbgAck   <= 1'b0;
            rDbgRd    <= 1'b0;
            rCollide  <= 1'b0;
            rFwdA     <= 1'b0;
            rFwdB     <= 1'b0;
            rFwdDataA <= {DATA_W{1'b0}};
            rFwdDataB <= {DATA_W{1'b0}};
            rHoldA    <= {DATA_W{1'b0}};
            rHoldB    <= {DATA_W{1'b0}};
            rDbgHold  <= {DATA_W{1'b0}};
            rAddrA    <= {ADDR_W{1'b0}};
            rAddrB    <= {ADDR_W{1'b0}};
            rDInA     <= {DATA_W{1'b0}};
            rDInB     <= {DATA_W{1'b0}};
        end else begin
            case (rState)
                CLEAR: begin
                    if (rClr == CLR_LAST) begin
                        rState <= RUN;
                        rReady <= 1'b1;
                    end else begin
                        rClr <= rClr + CLR_ONE;
                    end
                end
                RUN: begin
                    rState <= RUN;
                    rReady <= 1'b1;
                end
                default: begin
                    rState <= CLEAR;
                    rClr   <= {CLR_W{1'b0}};
                    rReady <= 1'b0;
                end
            endcase
            rValidA   <= coreRdA;
            rValidB   <= coreRdB;
            rDbgAck   <= dbgGnt;
            rDbgRd    <= dbgRd;
            rCollide  <= suppressB;
            rFwdA     <= fwdA;
            rFwdB     <= fwdB;
            rFwdDataA <= dinB;
            rFwdDataB <= dinA;
            rHoldA    <= rValidA ? rdDataA : rHoldA;
            rHoldB    <= rValidB ? rdDataB : rHoldB;
            rDbgHold  <= rDbgRd ? rdDataB : rDbgHold;
            rAddrA    <= addrA;
            rAddrB    <= addrB;
            rDInA     <= dinA;
            rDInB     <= dinB;
        end
    end

    assign oAddrA          = addrA;
    assign oDInA           = dinA;
    assign oWriteA         = writeA;
    assign oAddrB          = addrB;
    assign oDInB           = dinB;
    assign oWriteB         = writeB;
    assign oReady          = rReady;
    assign oCollide        = rCollide;
    assign bus.oCoreValidA = rValidA;
    assign bus.oCoreDataA  = rValidA ? rdDataA : rHoldA;
    assign bus.oCoreValidB = rValidB;
    assign bus.oCoreDataB  = rValidB ? rdDataB : rHoldB;
    assign bus.oDbgGnt     = dbgGnt;
    assign bus.oDbgAck     = rDbgAck;
    assign bus.oDbgData    = rDbgRd ? rdDataB : rDbgHold;
endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Bench for gpr_access_ctrl: directed vector table, clear/reset sequences and random
// traffic checked against a register-array reference model.
module tb_gpr_access_ctrl;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NREG = 64;

    logic          iClk = 1'b0;
    logic          iRst;
    logic [AW-1:0] oAddrA, oAddrB;
    logic [DW-1:0] oDInA, oDInB, iDOutA, iDOutB;
    logic          oWriteA, oWriteB, oReady, oCollide;

    gpr_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    gpr_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(NREG)) dut (
        .iClk(iClk), .iRst(iRst), .bus(bus),
        .oAddrA(oAddrA), .oDInA(oDInA), .oWriteA(oWriteA), .iDOutA(iDOutA),
        .oAddrB(oAddrB), .oDInB(oDInB), .oWriteB(oWriteB), .iDOutB(iDOutB),
        .oReady(oReady), .oCollide(oCollide)
    );

    always #5 iClk = ~iClk;

    // Synchronous dual-port register file, read data one cycle after the address.
    logic [DW-1:0] rfMem [NREG];
    always @(posedge iClk) begin
        if (oWriteA) rfMem[oAddrA] <= oDInA;
        if (oWriteB) rfMem[oAddrB] <= oDInB;
        iDOutA <= rfMem[oAddrA];
        iDOutB <= rfMem[oAddrB];
    end

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents as seen after each cycle's writes.
    logic [DW-1:0] refMem [NREG];
    int            clrCnt;
    bit            refRun;
    bit            expValidA, expValidB, expAck, expCollide;
    logic [DW-1:0] expDataA, expDataB, expDbgData;

    task automatic drive(input bit ra, input bit wa, input logic [5:0] aa, input logic [31:0] da,
                         input bit rb, input bit wb, input logic [5:0] ab, input logic [31:0] db,
                         input bit dr, input bit dw, input logic [5:0] dad, input logic [31:0] dd);
        bus.iCoreReqA = ra; bus.iCoreWrA = wa; bus.iCoreAddrA = aa; bus.iCoreDataA = da;
        bus.iCoreReqB = rb; bus.iCoreWrB = wb; bus.iCoreAddrB = ab; bus.iCoreDataB = db;
        bus.iDbgReq = dr; bus.iDbgWr = dw; bus.iDbgAddr = dad; bus.iDbgData = dd;
    endtask

    task automatic driveIdle();
        drive(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic preEdge();
        bit gnt, wA, wB, bRd, coll;
        logic [5:0] bAddr;
        logic [31:0] bData;
        #1;
        gnt = 1'b0; wB = 1'b0; bRd = 1'b0; bAddr = 6'd0; bData = 32'd0;
        if (iRst) begin
            chk("rst_writeA", {31'd0, oWriteA}, 32'd0);
            chk("rst_writeB", {31'd0, oWriteB}, 32'd0);
            chk("rst_gnt", {31'd0, bus.oDbgGnt}, 32'd0);
            clrCnt = 0; refRun = 1'b0;
            expValidA = 1'b0; expValidB = 1'b0; expAck = 1'b0; expCollide = 1'b0;
            expDataA = 32'd0; expDataB = 32'd0; expDbgData = 32'd0;
        end else if (!refRun) begin
            chk("clr_writeA", {31'd0, oWriteA}, 32'd1);
            chk("clr_addrA", {26'd0, oAddrA}, 32'(2 * clrCnt));
            chk("clr_dataA", oDInA, 32'd0);
            chk("clr_writeB", {31'd0, oWriteB}, 32'd1);
            chk("clr_addrB", {26'd0, oAddrB}, 32'(2 * clrCnt + 1));
            chk("clr_gnt", {31'd0, bus.oDbgGnt}, 32'd0);
            clrCnt++;
            if (clrCnt == NREG / 2) begin
                refRun = 1'b1;
                foreach (refMem[i]) refMem[i] = 32'd0;
            end
            expValidA = 1'b0; expValidB = 1'b0; expAck = 1'b0; expCollide = 1'b0;
        end else begin
            gnt = bus.iDbgReq && !bus.iCoreReqB;
            chk("gnt", {31'd0, bus.oDbgGnt}, {31'd0, gnt});
            wA = bus.iCoreReqA && bus.iCoreWrA;
            if (bus.iCoreReqB) begin
                bAddr = bus.iCoreAddrB; bData = bus.iCoreDataB;
                wB = bus.iCoreWrB; bRd = !bus.iCoreWrB;
            end else if (gnt) begin
                bAddr = bus.iDbgAddr; bData = bus.iDbgData;
                wB = bus.iDbgWr; bRd = !bus.iDbgWr;
            end
            coll = wA && wB && (bAddr == bus.iCoreAddrA);
            if (wB && !coll) refMem[bAddr] = bData;
            if (wA) refMem[bus.iCoreAddrA] = bus.iCoreDataA;
            expValidA = bus.iCoreReqA && !bus.iCoreWrA;
            if (expValidA) expDataA = refMem[bus.iCoreAddrA];
            expValidB = bus.iCoreReqB && !bus.iCoreWrB;
            if (expValidB) expDataB = refMem[bAddr];
            expAck = gnt;
            if (gnt && bRd) expDbgData = refMem[bAddr];
            expCollide = coll;
        end
    endtask

    task automatic postEdge();
        @(posedge iClk);
        #1;
        chk("validA", {31'd0, bus.oCoreValidA}, {31'd0, expValidA});
        chk("dataA", bus.oCoreDataA, expDataA);
        chk("validB", {31'd0, bus.oCoreValidB}, {31'd0, expValidB});
        chk("dataB", bus.oCoreDataB, expDataB);
        chk("dbgAck", {31'd0, bus.oDbgAck}, {31'd0, expAck});
        chk("dbgData", bus.oDbgData, expDbgData);
        chk("collide", {31'd0, oCollide}, {31'd0, expCollide});
        chk("ready", {31'd0, oReady}, {31'd0, refRun});
    endtask

    task automatic step();
        preEdge();
        postEdge();
    endtask

    // Clear phase with requests pending; oReady must stay low for exactly NREG/2 cycles.
    task automatic clearPhase();
        int lowCnt;
        lowCnt = 0;
        while (!oReady && lowCnt < 40) begin
            lowCnt++;
            drive(1'b1, 1'b0, 6'(lowCnt), 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd4, 32'h5a5a5a5a);
            step();
        end
        chk("ready_low_cycles", 32'(lowCnt), 32'd32);
    endtask

    task automatic sweepZero();
        for (int k = 0; k < NREG / 2; k++) begin
            drive(1'b1, 1'b0, 6'(2 * k), 32'd0, 1'b1, 1'b0, 6'(2 * k + 1), 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
            step();
            chk("sweep_validA", {31'd0, bus.oCoreValidA}, 32'd1);
            chk("sweep_dataA", bus.oCoreDataA, 32'd0);
            chk("sweep_validB", {31'd0, bus.oCoreValidB}, 32'd1);
            chk("sweep_dataB", bus.oCoreDataB, 32'd0);
        end
        driveIdle();
        step();
    endtask

    typedef struct {
        bit ra; bit wa; logic [5:0] aa; logic [31:0] da;
        bit rb; bit wb; logic [5:0] ab; logic [31:0] db;
        bit dr; bit dw; logic [5:0] dad; logic [31:0] dd;
        bit eGnt; bit eVA; logic [31:0] eDA; bit eVB; logic [31:0] eDB;
        bit eAck; logic [31:0] eDbg; bit eColl;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1,1,6'd5, 32'hDEADBEEF, 0,0,6'd0, 32'd0,        0,0,6'd0, 32'd0,        0,0,32'd0,        0,32'd0,        0,32'd0,        0};
        tbl[1]  = '{0,0,6'd0, 32'd0,        1,0,6'd5, 32'd0,        0,0,6'd0, 32'd0,        0,0,32'd0,        1,32'hDEADBEEF, 0,32'd0,        0};
        tbl[2]  = '{1,1,6'd9, 32'h11111111, 1,1,6'd9, 32'h22222222, 0,0,6'd0, 32'd0,        0,0,32'd0,        0,32'd0,        0,32'd0,        1};
        tbl[3]  = '{1,0,6'd9, 32'd0,        1,0,6'd5, 32'd0,        0,0,6'd0, 32'd0,        0,1,32'h11111111, 1,32'hDEADBEEF, 0,32'd0,        0};
        tbl[4]  = '{1,1,6'd3, 32'hCAFEF00D, 1,0,6'd3, 32'd0,        0,0,6'd0, 32'd0,        0,0,32'd0,        1,32'hCAFEF00D, 0,32'd0,        0};
        tbl[5]  = '{1,0,6'd12,32'd0,        1,1,6'd12,32'hAAAA5555, 0,0,6'd0, 32'd0,        0,1,32'hAAAA5555, 0,32'd0,        0,32'd0,        0};
        tbl[6]  = '{1,1,6'd7, 32'h0000ABCD, 0,0,6'd0, 32'd0,        0,0,6'd0, 32'd0,        0,0,32'd0,        0,32'd0,        0,32'd0,        0};
        tbl[7]  = '{0,0,6'd0, 32'd0,        1,0,6'd3, 32'd0,        1,0,6'd7, 32'd0,        0,0,32'd0,        1,32'hCAFEF00D, 0,32'd0,        0};
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = '{0,0,6'd0, 32'd0,        0,0,6'd0, 32'd0,        1,0,6'd7, 32'd0,        1,0,32'd0,        0,32'd0,        1,32'h0000ABCD, 0};
        tbl[11] = '{1,1,6'd20,32'h87654321, 0,0,6'd0, 32'd0,        1,1,6'd20,32'h12345678, 1,0,32'd0,        0,32'd0,        1,32'h0000ABCD, 1};
        tbl[12] = '{1,0,6'd20,32'd0,        0,0,6'd0, 32'd0,        1,0,6'd3, 32'd0,        1,1,32'h87654321, 0,32'd0,        1,32'hCAFEF00D, 0};
        tbl[13] = '{0,0,6'd0, 32'd0,        0,0,6'd0, 32'd0,        0,0,6'd0, 32'd0,        0,0,32'd0,        0,32'd0,        0,32'hCAFEF00D, 0};

        iRst = 1'b1;
        driveIdle();
        step();
        step();
        iRst = 1'b0;
        clearPhase();
        sweepZero();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db,
                  tbl[i].dr, tbl[i].dw, tbl[i].dad, tbl[i].dd);
            preEdge();
            chk($sformatf("tbl%0d_gnt", i), {31'd0, bus.oDbgGnt}, {31'd0, tbl[i].eGnt});
            postEdge();
            chk($sformatf("tbl%0d_validA", i), {31'd0, bus.oCoreValidA}, {31'd0, tbl[i].eVA});
            if (tbl[i].eVA) chk($sformatf("tbl%0d_dataA", i), bus.oCoreDataA, tbl[i].eDA);
            chk($sformatf("tbl%0d_validB", i), {31'd0, bus.oCoreValidB}, {31'd0, tbl[i].eVB});
            if (tbl[i].eVB) chk($sformatf("tbl%0d_dataB", i), bus.oCoreDataB, tbl[i].eDB);
            chk($sformatf("tbl%0d_ack", i), {31'd0, bus.oDbgAck}, {31'd0, tbl[i].eAck});
            chk($sformatf("tbl%0d_dbgData", i), bus.oDbgData, tbl[i].eDbg);
            chk($sformatf("tbl%0d_collide", i), {31'd0, oCollide}, {31'd0, tbl[i].eColl});
        end

        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
            step();
        end

        iRst = 1'b1;
        driveIdle();
        step();
        iRst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 6'd1, 32'd0, 1'b1, 1'b0, 6'd2, 32'd0, 1'b1, 1'b0, 6'd3, 32'd0);
            step();
        end
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        clearPhase();
        sweepZero();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/gpr_access_ctrl.md
# gpr_access_ctrl

Access controller for the core's 64×32 dual-port general-purpose register file. It sits between the register file and its two requesters: the core datapath, which has two ports, and a single-port debug interface. After every reset it clears all 64 registers to zero. In normal operation it arbitrates the debug requester onto port B, resolves same-address write collisions, and forwards write data to a colliding read on the other port.

## Interface
- ADDR_W, 6, register address width
- DATA_W, 32, register data width
- DEPTH, 64, number of registers; must equal 2^ADDR_W and be even
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  synchronous reset, active-high
- iCoreReqA / iCoreWrA  in  1 / 1  core port A access request / write select
- iCoreAddrA  in  ADDR_W  core port A address
- iCoreDataA  in  DATA_W  core port A write data
- oCoreDataA  out  DATA_W  core port A read data
- oCoreValidA  out  1  core port A read data valid
- iCoreReqB, iCoreWrB, iCoreAddrB, iCoreDataB, oCoreDataB, oCoreValidB: same as port A, for port B
- iDbgReq / iDbgWr  in  1 / 1  debug access request / write select
- iDbgAddr  in  ADDR_W  debug address
- iDbgData  in  DATA_W  debug write data
- oDbgGnt  out  1  debug access issued this cycle
- oDbgAck  out  1  debug access complete
- oDbgData  out  DATA_W  debug read data
- oAddrA, oDInA, oWriteA  out  ADDR_W, DATA_W, 1  register file port A drive
- iDOutA  in  DATA_W  register file port A read data
- oAddrB, oDInB, oWriteB, iDOutB: same as port A, for port B
- oReady  out  1  clear sequence done, accesses accepted
- oCollide  out  1  one-cycle pulse, a write was suppressed

## Operation
- States: CLEAR and RUN. iRst forces CLEAR and sets clear counter rClr to 0.
- While iRst is high:
  - oWriteA = oWriteB = 0.
  - All registered outputs are 0: oCoreValidA/B, oDbgAck, oDbgData, oCoreDataA/B hold register, oCollide, oReady.
- CLEAR, iRst low, one cycle per rClr value k = 0..DEPTH/2-1:
  - Port A writes address 2k; port B writes address 2k+1; data is 0.
  - After k = DEPTH/2-1, go to RUN.
  - Core and debug requests are ignored: no writes, no valids, oDbgGnt = 0.
- RUN: oReady = 1.
  - Core port A passes straight through to register file port A in the same cycle. oWriteA = iCoreReqA & iCoreWrA.
  - Core port B has priority on register file port B.
  - oDbgGnt = iDbgReq & !iCoreReqB. When granted, the debug access drives port B that cycle.
  - A debug requester holding iDbgReq after a grant issues a new access each granted cycle.
- Write collision: both ports write the same address in the same cycle.
  - Port A wins. oWriteB is forced to 0.
  - oCollide pulses in the next cycle.
  - The suppressed write is a core B write or a debug write, whichever owns port B. A suppressed debug write is still acked.
- Forwarding: one port reads address X while the other port performs an unsuppressed write to X in the same cycle.
  - The read returns the written data, not the stale iDOut value.
  - This is implemented with a registered select flag plus the registered write data.
- Port idle: outputs hold the previous address and data, with write low.
- Reset mid-CLEAR or mid-RUN: return to CLEAR at rClr = 0. Pending valids and acks are dropped.

## Timing
- Request in cycle N: the register file samples it at the end of N.
- Read result in cycle N+1:
  - oCoreValidX = 1, oCoreDataX = iDOutX or the forwarded value.
  - oCoreValidX is not asserted for writes.
- Debug grant in cycle N: oDbgAck = 1 in N+1, for reads and writes. For reads, oDbgData is valid in N+1 and holds until the next debug read ack.
- Writes are visible to any read issued in cycle N+1 or later. The register file read-after-write latency is 1 cycle.
- Clear duration: DEPTH/2 cycles after iRst falls (32 at default). oReady rises in cycle DEPTH/2+1 after iRst falls.
- Full throughput in RUN: both ports every cycle, no stalls.

## Test plan
- Reset release, then read every address on both ports.
  - oReady = 0 for exactly 32 cycles, then 1.
  - All 64 reads return 0x00000000, with valid one cycle after each request.
- Core A writes 0xDEADBEEF to reg 5 in cycle N; core B reads reg 5 in cycle N+1.
  - oCoreValidB = 1 and oCoreDataB = 0xDEADBEEF in N+2.
- Core A writes 0x11111111 to reg 9 while core B writes 0x22222222 to reg 9 in the same cycle.
  - oCollide = 1 the next cycle.
  - A later read of reg 9 returns 0x11111111.
- Core A writes 0xCAFEF00D to reg 3 while core B reads reg 3 in the same cycle.
  - oCoreDataB = 0xCAFEF00D the next cycle (forwarded).
- Debug read of reg 7 (preloaded 0x0000ABCD) while iCoreReqB is high for 3 cycles.
  - oDbgGnt = 0 for those 3 cycles, then 1 for one cycle.
  - oDbgAck = 1 and oDbgData = 0x0000ABCD the cycle after the grant.
- Assert iRst at rClr = 10, release, then read.
  - Clear restarts at addresses 0/1 and takes 32 full cycles.
  - No valid or ack is issued during the clear.
  - All registers read 0.
